// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//   Connects the pipeline MEM stage to a single-outstanding request/ack data bus.
//   An aligned load or store seen in IDLE stalls the pipeline, issues one bus
//   transaction and waits for the ack. If no ack arrives in time the access is
//   aborted. The returned data is then held on mem_din until the pipeline
//   advances with mem_en.
//
// Parameters
//   TIMEOUT      maximum number of REQ cycles before abort (1..255)
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   mem_ren      load request from the MEM stage
//   mem_wen      store request (has priority over mem_ren)
//   mem_addr     byte address
//   mem_dout     store data
//   mem_en       MEM-stage advance enable
//   mem_din      load data back to MEM/WB (registered)
//   mem_stall    pipeline hold request (combinational)
//   align_err    one-cycle pulse on a misaligned request
//   bus_timeout  one-cycle pulse on an aborted access
//   bus_req      bus request (registered)
//   bus_we       bus write strobe (registered)
//   bus_addr     word-aligned bus address (registered)
//   bus_wdata    bus write data (registered)
//   bus_rdata    bus read data, valid with bus_ack
//   bus_ack      single-cycle bus completion strobe
//   access_cnt   completed-access counter, wraps, debug only
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic        mem_en,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        align_err,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [15:0] access_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Wait-counter value at which the access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [31:0] rd_data_r;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic        align_err_r;
  logic        align_seen_r;
  logic        bus_timeout_r;
  logic [15:0] access_cnt_r;

  logic        req_any_s;
  logic        aligned_s;
  logic        valid_s;
  logic        misalign_s;
  logic        stall_s;

  // Request decode and the stall request, which must rise in the same cycle
  // the request is seen; reset forces it low.
  always_comb begin
    req_any_s  = mem_ren | mem_wen;
    aligned_s  = (mem_addr[1:0] == 2'b00);
    valid_s    = req_any_s & aligned_s;
    misalign_s = req_any_s & ~aligned_s;
    stall_s    = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else if (state_r == ST_REQ) begin
      stall_s = 1'b1;
    end else if (state_r == ST_IDLE) begin
      stall_s = valid_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Access sequencer: state, bus outputs, read register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 8'd0;
      rd_data_r     <= 32'd0;
      bus_req_r     <= 1'b0;
      bus_we_r      <= 1'b0;
      bus_addr_r    <= 32'd0;
      bus_wdata_r   <= 32'd0;
      align_err_r   <= 1'b0;
      align_seen_r  <= 1'b0;
      bus_timeout_r <= 1'b0;
      access_cnt_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus_timeout_r <= 1'b0;
          if (valid_s) begin
            state_r      <= ST_REQ;
            bus_req_r    <= 1'b1;
            bus_we_r     <= mem_wen;
            bus_addr_r   <= {mem_addr[31:2], 2'b00};
            bus_wdata_r  <= mem_dout;
            wait_cnt_r   <= 8'd0;
            align_err_r  <= 1'b0;
            align_seen_r <= 1'b0;
          end else if (misalign_s) begin
            // Flag once per held request; an advancing pipeline (mem_en)
            // presents a new request next cycle, so re-arm then.
            align_err_r  <= ~align_seen_r;
            align_seen_r <= ~mem_en;
          end else begin
            align_err_r  <= 1'b0;
            align_seen_r <= 1'b0;
          end
        end
        ST_REQ: begin
          align_err_r  <= 1'b0;
          align_seen_r <= 1'b0;
          if (bus_ack) begin
            // An ack on the final wait cycle still completes the access.
            state_r      <= ST_DONE;
            bus_req_r    <= 1'b0;
            access_cnt_r <= access_cnt_r + 16'd1;
            if (bus_we_r) begin
              rd_data_r <= rd_data_r;
            end else begin
              rd_data_r <= bus_rdata;
            end
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r       <= ST_DONE;
            bus_req_r     <= 1'b0;
            rd_data_r     <= 32'd0;
            bus_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          bus_timeout_r <= 1'b0;
          align_err_r   <= 1'b0;
          align_seen_r  <= 1'b0;
          if (mem_en) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          bus_req_r     <= 1'b0;
          bus_timeout_r <= 1'b0;
          align_err_r   <= 1'b0;
          align_seen_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_din     = rd_data_r;
  assign mem_stall   = stall_s;
  assign align_err   = align_err_r;
  assign bus_timeout = bus_timeout_r;
  assign bus_req     = bus_req_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign access_cnt  = access_cnt_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//   Self-checking bench for dmem_bridge (TIMEOUT = 4). A transaction-level
//   reference model predicts stall length, bus fields, returned data, the
//   timeout/alignment pulses and the access count for each access.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen, mem_en;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall, align_err, bus_timeout;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [15:0] access_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] exp_din = 32'd0;
  logic [15:0] exp_cnt = 16'd0;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_en(mem_en),
    .mem_din(mem_din), .mem_stall(mem_stall), .align_err(align_err),
    .bus_timeout(bus_timeout), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .access_cnt(access_cnt)
  );

  always #5 clk = ~clk;

  // One MEM-stage access from IDLE to the return to IDLE.
  // ack_at: REQ cycle (1-based) carrying bus_ack; 0 or > TO means no ack.
  // Starts and ends #1 after a rising edge with the DUT in IDLE.
  task automatic do_access(input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata,
                           input int hold);
    int          stall_cnt, req_cyc, pulses, exp_stall;
    bit          done, exp_to;
    logic [31:0] exp_baddr;
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = wd;
    mem_en   = 1'b0;
    if (addr[1:0] != 2'b00) begin
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++;
        if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin
          bad++;
          $display("FAIL misalign_nostall: stall=%b req=%b want 0/0", mem_stall, bus_req);
        end
        if (align_err === 1'b1) pulses++;
      end
      total++;
      if (pulses != 1) begin
        bad++;
        $display("FAIL misalign_pulses: got %0d want 1", pulses);
      end
      total++;
      if (mem_din !== exp_din) begin
        bad++;
        $display("FAIL misalign_din: got %h want %h", mem_din, exp_din);
      end
      mem_en = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      exp_baddr = addr;
      if (ack_at >= 1 && ack_at <= TO) begin
        exp_stall = ack_at + 1;
        exp_to    = 1'b0;
        if (!wen) exp_din = rdata;
        exp_cnt++;
      end else begin
        exp_stall = TO + 1;
        exp_to    = 1'b1;
        exp_din   = 32'd0;
      end
      stall_cnt = 0;
      req_cyc   = 0;
      done      = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (!mem_stall) begin
          done = 1'b1;
        end else begin
          stall_cnt++;
          if (bus_req) begin
            req_cyc++;
            total++;
            if (bus_we !== wen || bus_addr !== exp_baddr || bus_wdata !== wd) begin
              bad++;
              $display("FAIL bus_fields: we=%b addr=%h wdata=%h want %b %h %h",
                       bus_we, bus_addr, bus_wdata, wen, exp_baddr, wd);
            end
            if (req_cyc == ack_at) begin
              bus_ack   = 1'b1;
              bus_rdata = rdata;
            end
          end
          @(posedge clk);
          #1;
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
      end
      total++;
      if (!done) begin
        bad++;
        $display("FAIL stall_bound: stall never released");
      end
      total++;
      if (stall_cnt != exp_stall) begin
        bad++;
        $display("FAIL stall_len: got %0d want %0d", stall_cnt, exp_stall);
      end
      total++;
      if (mem_din !== exp_din || bus_timeout !== exp_to || access_cnt !== exp_cnt || bus_req !== 1'b0) begin
        bad++;
        $display("FAIL done_state: din=%h to=%b cnt=%0d req=%b want %h %b %0d 0",
                 mem_din, bus_timeout, access_cnt, bus_req, exp_din, exp_to, exp_cnt);
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        bus_ack = ($urandom_range(0, 1) == 1);  // stray ack in DONE
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (mem_din !== exp_din || mem_stall !== 1'b0 || bus_req !== 1'b0 ||
            bus_timeout !== 1'b0 || access_cnt !== exp_cnt) begin
          bad++;
          $display("FAIL done_hold: din=%h stall=%b req=%b to=%b cnt=%0d want %h 0 0 0 %0d",
                   mem_din, mem_stall, bus_req, bus_timeout, access_cnt, exp_din, exp_cnt);
        end
      end
      @(negedge clk);
      mem_en = 1'b1;
      @(posedge clk);
      #1;
    end
    mem_en  = 1'b0;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_en = 1'b0;
    mem_addr = 32'd0; mem_dout = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_din !== 32'd0 || mem_stall !== 1'b0 || align_err !== 1'b0 || bus_timeout !== 1'b0 ||
        bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'd0 || bus_wdata !== 32'd0 ||
        access_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: din=%h stall=%b req=%b addr=%h cnt=%0d want all zero",
               mem_din, mem_stall, bus_req, bus_addr, access_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_din = 32'd0;
    exp_cnt = 16'd0;
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEBABE, 0);
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 32'h204, 32'h12345678, 1, 32'h55AA55AA, 0);
    // both strobes set: the store wins
    do_access(1'b1, 1'b1, 32'h208, 32'hA5A5A5A5, 2, 32'h11111111, 1);
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h0, 0);
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 32'h400, 32'h0, 4, 32'hDEADBEEF, 0);
    do_access(1'b1, 1'b0, 32'h404, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 32'h500, 32'h0, 2, 32'h01020304, 3);
    do_access(1'b1, 1'b0, 32'h504, 32'h0, 1, 32'h05060708, 0);
  endtask

  task automatic test_reset_mid_req();
    mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h300; mem_en = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_req_setup: bus_req=%b want 1", bus_req);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus_req !== 1'b0 || mem_stall !== 1'b0 || bus_addr !== 32'd0 || bus_we !== 1'b0 ||
        mem_din !== 32'd0 || access_cnt !== 16'd0 || bus_timeout !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: req=%b stall=%b addr=%h din=%h cnt=%0d want 0",
               bus_req, mem_stall, bus_addr, mem_din, access_cnt);
    end
    exp_din = 32'd0;
    exp_cnt = 16'd0;
    mem_ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus_ack = 1'b1;
    bus_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b0 || access_cnt !== 16'd0 || mem_din !== 32'd0 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL late_ack: req=%b cnt=%0d din=%h stall=%b want 0 0 0 0",
               bus_req, access_cnt, mem_din, mem_stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic        r, w;
    logic [31:0] a;
    for (int n = 0; n < 30; n++) begin
      w = ($urandom_range(0, 2) == 0);
      r = w ? ($urandom_range(0, 1) == 1) : 1'b1;
      a = {$urandom, 2'b00};
      a = {a[31:2], 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_access(r, w, a, $urandom, $urandom_range(0, TO + 1), $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
